// File: rtl/pc_pkg.sv
// Shared types and default sizes for the fetch-stage program counter and
// its return-address stack.
package pc_pkg;

  localparam int unsigned PC_D_DEFAULT      = 12;
  localparam int unsigned RAS_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_REL  = 3'd1,
    PC_ABS  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_sel_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the
// oldest entry; the overflow and underflow flags stay set until reset.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned D     = PC_D_DEFAULT,
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [D-1:0]               push_data,
  output logic [D-1:0]               top,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [D-1:0]  mem_r [DEPTH];
  logic [PW-1:0] sp_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          underflow_r;

  // sp_r addresses the next free slot; because DEPTH is a power of two it
  // wraps onto the oldest entry once the stack is full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {D{1'b0}};
      end
      sp_r        <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (push) begin
      mem_r[sp_r] <= push_data;
      sp_r        <= sp_r + PTR_ONE;
      if (count_r == CNT_FULL) begin
        overflow_r <= 1'b1;
      end else begin
        count_r <= count_r + CNT_ONE;
      end
    end else if (pop) begin
      if (count_r != {CW{1'b0}}) begin
        sp_r    <= sp_r - PTR_ONE;
        count_r <= count_r - CNT_ONE;
      end else begin
        underflow_r <= 1'b1;
      end
    end else begin
      sp_r <= sp_r;
    end
  end

  assign top       = mem_r[sp_r - PTR_ONE];
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection, call/return
// through pc_ras, stall, and a halt state left only through reset.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned  D          = PC_D_DEFAULT,
  parameter int unsigned  RAS_DEPTH  = RAS_DEPTH_DEFAULT,
  parameter logic [D-1:0] START_ADDR = {D{1'b0}}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           halt,
  input  logic                           rel_jump_en,
  input  logic                           abs_jump_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic [D-1:0]                   jump_offset,
  input  logic [D-1:0]                   jump_target,
  output logic [D-1:0]                   prog_ctr_out,
  output logic                           done,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam logic [D-1:0] PC_ONE = D'(1'b1);

  pc_state_e    state_r, state_next_s;
  pc_sel_e      sel_s;
  logic [D-1:0] pc_r, pc_next_s, pc_inc_s;
  logic         done_r;
  logic         advance_s, push_s, pop_s;
  logic [D-1:0] ras_top_s;
  logic         ras_empty_s;

  assign pc_inc_s  = pc_r + PC_ONE;
  assign advance_s = (state_r == RUN) && !stall && !halt;
  assign push_s    = advance_s && (sel_s == PC_CALL);
  assign pop_s     = advance_s && (sel_s == PC_RET);

  // Priority encode the control requests; lower-priority ones are dropped.
  always_comb begin
    sel_s = PC_INC;
    if (ret_en) begin
      sel_s = PC_RET;
    end else if (call_en) begin
      sel_s = PC_CALL;
    end else if (abs_jump_en) begin
      sel_s = PC_ABS;
    end else if (rel_jump_en) begin
      sel_s = PC_REL;
    end else begin
      sel_s = PC_INC;
    end
  end

  // Next-PC mux; a return on an empty stack falls through to PC+1.
  always_comb begin
    pc_next_s = pc_inc_s;
    case (sel_s)
      PC_RET:  pc_next_s = ras_empty_s ? pc_inc_s : ras_top_s;
      PC_CALL: pc_next_s = jump_target;
      PC_ABS:  pc_next_s = jump_target;
      PC_REL:  pc_next_s = pc_r + jump_offset;
      PC_INC:  pc_next_s = pc_inc_s;
      default: pc_next_s = pc_inc_s;
    endcase
  end

  // Halt is only honoured when not stalled; HALTED is left only by reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (halt && !stall) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = RUN;
        end
      end
      HALTED:  state_next_s = HALTED;
      default: state_next_s = RUN;
    endcase
  end

  // State, PC and halted-flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= RUN;
      pc_r    <= START_ADDR;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == HALTED);
      if (advance_s) begin
        pc_r <= pc_next_s;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  pc_ras #(
    .D     (D),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign prog_ctr_out = pc_r;
  assign done         = done_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts each
// cycle's outputs, plus directed checks against hand-computed addresses.
module tb_pc_unit;

  logic        clk;
  logic        reset, stall, halt, rel_jump_en, abs_jump_en, call_en, ret_en;
  logic [11:0] jump_offset, jump_target;
  logic [11:0] prog_ctr_out;
  logic        done;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  typedef struct packed {
    logic [11:0] pc;
    logic        done;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_ras[$];
  logic [11:0] m_pc;
  logic        m_halted, m_ovf, m_unf;
  int          checks = 0;
  int          errors = 0;

  pc_unit #(.D(12), .RAS_DEPTH(4), .START_ADDR(12'h000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .rel_jump_en(rel_jump_en), .abs_jump_en(abs_jump_en),
    .call_en(call_en), .ret_en(ret_en),
    .jump_offset(jump_offset), .jump_target(jump_target),
    .prog_ctr_out(prog_ctr_out), .done(done), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then score the DUT.
  task automatic step(input logic r, input logic st, input logic hl, input logic rl,
                      input logic ab, input logic cl, input logic rt,
                      input logic [11:0] off, input logic [11:0] tgt);
    exp_t e;
    reset = r; stall = st; halt = hl; rel_jump_en = rl; abs_jump_en = ab;
    call_en = cl; ret_en = rt; jump_offset = off; jump_target = tgt;
    if (!r) begin
      m_pc = 12'h000; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
    end else if (m_halted || st) begin
      m_pc = m_pc;
    end else if (hl) begin
      m_halted = 1'b1;
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = 12'(m_ras.pop_back());
      else begin
        m_pc = m_pc + 12'd1; m_unf = 1'b1;
      end
    end else if (cl) begin
      m_ras.push_back(int'(m_pc + 12'd1));
      if (m_ras.size() > 4) begin
        void'(m_ras.pop_front()); m_ovf = 1'b1;
      end
      m_pc = tgt;
    end else if (ab) m_pc = tgt;
    else if (rl) m_pc = m_pc + off;
    else m_pc = m_pc + 12'd1;
    e.pc = m_pc; e.done = m_halted; e.cnt = 3'(m_ras.size());
    e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("pc",   32'(prog_ctr_out),  32'(e.pc));
    check_val("done", 32'(done),          32'(e.done));
    check_val("cnt",  32'(ras_count),     32'(e.cnt));
    check_val("ovf",  32'(ras_overflow),  32'(e.ovf));
    check_val("unf",  32'(ras_underflow), 32'(e.unf));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
  endtask
  task automatic jmp(input logic [11:0] t);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, t);
  endtask
  task automatic rel(input logic [11:0] o);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, o, 12'h000);
  endtask
  task automatic call(input logic [11:0] t);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, t);
  endtask
  task automatic ret();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h000);
  endtask
  task automatic rst();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
  endtask

  initial begin
    logic [11:0] ret_exp [4];
    ret_exp[0] = 12'h501; ret_exp[1] = 12'h401; ret_exp[2] = 12'h301; ret_exp[3] = 12'h201;
    m_pc = 12'h000; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    reset = 1'b0; stall = 1'b0; halt = 1'b0; rel_jump_en = 1'b0; abs_jump_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; jump_offset = 12'h000; jump_target = 12'h000;

    rst(); rst();
    check_val("reset_pc", 32'(prog_ctr_out), 32'h000);
    for (int i = 1; i <= 5; i++) begin
      idle();
      check_val("inc_pc", 32'(prog_ctr_out), 32'(i));
    end

    jmp(12'h010); rel(12'hFFC);
    check_val("rel_back", 32'(prog_ctr_out), 32'h00C);
    jmp(12'hFFE); rel(12'h005);
    check_val("rel_wrap", 32'(prog_ctr_out), 32'h003);
    jmp(12'hFFF); idle();
    check_val("inc_wrap", 32'(prog_ctr_out), 32'h000);

    jmp(12'h020); call(12'h100);
    check_val("call_cnt", 32'(ras_count), 32'd1);
    idle(); idle(); idle();
    check_val("pre_ret", 32'(prog_ctr_out), 32'h103);
    ret();
    check_val("ret_pc", 32'(prog_ctr_out), 32'h021);
    check_val("ret_cnt", 32'(ras_count), 32'd0);

    call(12'h200); call(12'h300); call(12'h400); call(12'h500); call(12'h600);
    check_val("ovf_flag", 32'(ras_overflow), 32'd1);
    check_val("ovf_cnt", 32'(ras_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ret();
      check_val("nest_ret", 32'(prog_ctr_out), 32'(ret_exp[i]));
    end
    ret();
    check_val("unf_pc", 32'(prog_ctr_out), 32'h202);
    check_val("unf_flag", 32'(ras_underflow), 32'd1);

    jmp(12'h054); call(12'h300);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 12'h700);
    check_val("prio_pc", 32'(prog_ctr_out), 32'h055);
    check_val("prio_cnt", 32'(ras_count), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h700);
    check_val("stall_pc", 32'(prog_ctr_out), 32'h055);
    check_val("stall_cnt", 32'(ras_count), 32'd0);

    jmp(12'h034); rst();
    check_val("midrst_pc", 32'(prog_ctr_out), 32'h000);
    check_val("midrst_ovf", 32'(ras_overflow), 32'd0);
    check_val("midrst_unf", 32'(ras_underflow), 32'd0);

    jmp(12'h040);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    check_val("halt_stall", 32'(done), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    check_val("halt_done", 32'(done), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h003, 12'h123);
      check_val("halt_pc", 32'(prog_ctr_out), 32'h040);
    end
    rst();
    check_val("unhalt_pc", 32'(prog_ctr_out), 32'h000);
    check_val("unhalt_done", 32'(done), 32'd0);

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           12'($urandom), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
